// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM with memory-wait timeout supervision.
// Optional ADDI support (AEX/AWB states) is enabled by defining MC_CONTROL_ADDI_EN.
module mc_control_fsm #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    input  logic       zero,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       mem_timeout,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        REX    = 4'd6,
        RWB    = 4'd7,
        BEQ    = 4'd8,
        JMP    = 4'd9,
        AEX    = 4'd10,
        AWB    = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t      state_r;
    state_t      state_next_s;
    logic [7:0]  wait_cnt_r;
    logic [7:0]  wait_cnt_next_s;
    logic        waiting_s;
    logic        timeout_s;
    logic [15:0] ctl_s;

    // State and wait-counter registers; reset forces FETCH without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= FETCH;
            wait_cnt_r <= 8'd0;
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_cnt_next_s;
        end
    end

    // Next-state logic, timeout detection and wait-counter update.
    always_comb begin
        waiting_s    = (state_r == FETCH) || (state_r == MEMRD) || (state_r == MEMWR);
        timeout_s    = waiting_s && !mem_ready && (wait_cnt_r == MAX_WAIT_C);
        state_next_s = FETCH;
        case (state_r)
            FETCH: begin
                if (mem_ready) state_next_s = DECODE;
                else           state_next_s = FETCH;
            end
            DECODE: begin
                case (opcode)
                    OP_LW:   state_next_s = MEMADR;
                    OP_SW:   state_next_s = MEMADR;
                    OP_RTYP: state_next_s = REX;
                    OP_BEQ:  state_next_s = BEQ;
                    OP_J:    state_next_s = JMP;
`ifdef MC_CONTROL_ADDI_EN
                    OP_ADDI: state_next_s = AEX;
`endif
                    default: state_next_s = FETCH;
                endcase
            end
            MEMADR: begin
                if (opcode == OP_LW)      state_next_s = MEMRD;
                else if (opcode == OP_SW) state_next_s = MEMWR;
                else                      state_next_s = FETCH;
            end
            MEMRD: begin
                if (mem_ready)      state_next_s = MEMWB;
                else if (timeout_s) state_next_s = FETCH;
                else                state_next_s = MEMRD;
            end
            MEMWB: state_next_s = FETCH;
            MEMWR: begin
                if (mem_ready || timeout_s) state_next_s = FETCH;
                else                        state_next_s = MEMWR;
            end
            REX:   state_next_s = RWB;
            RWB:   state_next_s = FETCH;
            BEQ:   state_next_s = FETCH;
            JMP:   state_next_s = FETCH;
`ifdef MC_CONTROL_ADDI_EN
            AEX:   state_next_s = AWB;
            AWB:   state_next_s = FETCH;
`endif
            default: state_next_s = FETCH;
        endcase

        // A timeout in FETCH re-enters FETCH, so it restarts the count as well.
        if ((state_next_s != state_r) || timeout_s) begin
            wait_cnt_next_s = 8'd0;
        end else if (waiting_s && !mem_ready && (wait_cnt_r != 8'hFF)) begin
            wait_cnt_next_s = wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_next_s = wait_cnt_r;
        end
    end

    // Moore output decode; bus order matches the output assignment below.
    always_comb begin
        ctl_s = 16'd0;
        case (state_r)
            FETCH: begin
                ctl_s[15]   = mem_ready;    // PCWrite
                ctl_s[12]   = 1'b1;         // MemRead
                ctl_s[10]   = mem_ready;    // IRWrite
                ctl_s[5:4]  = 2'b01;
            end
            DECODE: ctl_s[5:4] = 2'b11;
            MEMADR: begin
                ctl_s[6]    = 1'b1;
                ctl_s[5:4]  = 2'b10;
            end
            MEMRD: begin
                ctl_s[13]   = 1'b1;
                ctl_s[12]   = 1'b1;
            end
            MEMWB: begin
                ctl_s[9]    = 1'b1;
                ctl_s[7]    = 1'b1;
            end
            MEMWR: begin
                ctl_s[13]   = 1'b1;
                ctl_s[11]   = 1'b1;
            end
            REX: begin
                ctl_s[6]    = 1'b1;
                ctl_s[3:2]  = 2'b10;
            end
            RWB: begin
                ctl_s[8]    = 1'b1;
                ctl_s[7]    = 1'b1;
            end
            BEQ: begin
                ctl_s[14]   = 1'b1;
                ctl_s[6]    = 1'b1;
                ctl_s[3:2]  = 2'b01;
                ctl_s[1:0]  = 2'b01;
            end
            JMP: begin
                ctl_s[15]   = 1'b1;
                ctl_s[1:0]  = 2'b10;
            end
`ifdef MC_CONTROL_ADDI_EN
            AEX: begin
                ctl_s[6]    = 1'b1;
                ctl_s[5:4]  = 2'b10;
            end
            AWB: ctl_s[7] = 1'b1;
`endif
            default: ctl_s = 16'd0;
        endcase
    end

    // Reset gates every output so nothing is requested while rst_n is low.
    assign {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
            RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource} = rst_n ? ctl_s : 16'd0;
    assign mem_timeout = rst_n & timeout_s;
    assign state       = state_r;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: directed scenarios plus randomized
// instruction/handshake streams checked against an instruction-plan reference model.
module tb_mc_control_fsm;

    localparam int MAX_WAIT = 4;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
`ifdef MC_CONTROL_ADDI_EN
    localparam bit ADDI_EN = 1'b1;
`else
    localparam bit ADDI_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       zero = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, mem_timeout;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;
    logic [15:0] ctl_bus;

    int n_checks = 0;
    int n_fail   = 0;
    int pc_loads = 0;

    // Reference model: current state, cycles waited, and the remaining states of the instruction.
    int m_state = 0;
    int m_cnt   = 0;
    int plan[$];

    always #5 clk = ~clk;

    assign ctl_bus = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                      RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    mc_control_fsm #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .mem_timeout(mem_timeout), .state(state)
    );

    function automatic bit is_wait(int s);
        return (s == 0) || (s == 3) || (s == 5);
    endfunction

    // Control word expected in each state, straight from the per-state signal lists.
    function automatic logic [15:0] exp_ctl(int s, logic rdy);
        logic pcw, pcc, iord, mr, mw, irw, m2r, rdst, rw, asa;
        logic [1:0] asb, aop, pcs;
        {pcw, pcc, iord, mr, mw, irw, m2r, rdst, rw, asa} = 10'd0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (s)
            0:  begin mr = 1'b1; pcw = rdy; irw = rdy; asb = 2'b01; end
            1:  asb = 2'b11;
            2:  begin asa = 1'b1; asb = 2'b10; end
            3:  begin mr = 1'b1; iord = 1'b1; end
            4:  begin rw = 1'b1; m2r = 1'b1; end
            5:  begin mw = 1'b1; iord = 1'b1; end
            6:  begin asa = 1'b1; aop = 2'b10; end
            7:  begin rw = 1'b1; rdst = 1'b1; end
            8:  begin asa = 1'b1; aop = 2'b01; pcc = 1'b1; pcs = 2'b01; end
            9:  begin pcw = 1'b1; pcs = 2'b10; end
            10: begin asa = 1'b1; asb = 2'b10; end
            11: rw = 1'b1;
            default: pcw = 1'b0;
        endcase
        return {pcw, pcc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, pcs};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_now(input string tag);
        logic exp_tmo;
        exp_tmo = is_wait(m_state) && (m_cnt == MAX_WAIT) && !mem_ready;
        chk({tag, "/state"}, 16'(state), 16'(m_state));
        chk({tag, "/ctrl"}, ctl_bus, exp_ctl(m_state, mem_ready));
        chk({tag, "/timeout"}, 16'(mem_timeout), 16'(exp_tmo));
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_advance();
        bit tmo, stall;
        tmo   = is_wait(m_state) && (m_cnt == MAX_WAIT) && !mem_ready;
        stall = is_wait(m_state) && !mem_ready && !tmo;
        if (tmo) begin
            plan.delete();
            m_state = 0;
            m_cnt   = 0;
        end else if (stall) begin
            if (m_cnt < 255) m_cnt++;
        end else begin
            if (m_state == 0) plan = {1};
            else if (m_state == 1) begin
                plan.delete();
                if (opcode == OP_LW)                 plan = {2, 3, 4};
                else if (opcode == OP_SW)            plan = {2, 5};
                else if (opcode == OP_RTYP)          plan = {6, 7};
                else if (opcode == OP_BEQ)           plan = {8};
                else if (opcode == OP_J)             plan = {9};
                else if (opcode == OP_ADDI && ADDI_EN) plan = {10, 11};
            end
            m_cnt   = 0;
            m_state = (plan.size() > 0) ? plan.pop_front() : 0;
        end
    endtask

    task automatic model_reset();
        plan.delete();
        m_state = 0;
        m_cnt   = 0;
    endtask

    // One clock: apply inputs, check against the model, then clock both.
    task automatic step(input logic [5:0] op, input logic rdy, input logic z, input string tag,
                        output logic [3:0] st, output logic [15:0] cb, output logic tmo);
        opcode = op; mem_ready = rdy; zero = z;
        #1;
        check_now(tag);
        st = state; cb = ctl_bus; tmo = mem_timeout;
        if (PCWrite || (PCWriteCond && zero)) pc_loads++;
        @(posedge clk);
        model_advance();
        #1;
    endtask

    function automatic logic [5:0] pick_op();
        case ($urandom_range(0, 6))
            0: return OP_LW;
            1: return OP_SW;
            2: return OP_RTYP;
            3: return OP_BEQ;
            4: return OP_J;
            5: return OP_ADDI;
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: observed time limit reached, required finish earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  st;
        logic [15:0] cb;
        logic        tmo;
        logic [15:0] seq;
        logic [7:0]  mask;
        logic        seen;
        int          n3, p0, bias;
        logic [5:0]  cur_op;

        // Asynchronous reset: outputs forced low before any clock edge.
        #1 rst_n = 1'b0;
        #2;
        chk("reset_state", 16'(state), 16'd0);
        chk("reset_ctrl", ctl_bus, 16'd0);
        chk("reset_timeout", 16'(mem_timeout), 16'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();

        // R-type with mem_ready tied high.
        seq = 16'd0; mask = 8'd0;
        for (int i = 0; i < 4; i++) begin
            step(OP_RTYP, 1'b1, 1'b0, "rtype", st, cb, tmo);
            seq = {seq[11:0], st};
            mask[i] = cb[7] & cb[8];
        end
        chk("rtype_seq", seq, 16'h0167);
        chk("rtype_regwrite_cycle", 16'(mask), 16'h0008);

        // Fetch timeout: mem_ready held low in FETCH.
        mask = 8'd0; seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(OP_LW, 1'b0, 1'b0, "fetch_wait", st, cb, tmo);
            mask[i] = tmo;
            seen = seen | cb[10];
        end
        chk("fetch_timeout_pulse", 16'(mask), 16'h0010);
        chk("fetch_irwrite_never", 16'(seen), 16'd0);

        // lw with three wait cycles in MEMRD.
        step(OP_LW, 1'b1, 1'b0, "lw", st, cb, tmo);
        step(OP_LW, 1'b1, 1'b0, "lw", st, cb, tmo);
        step(OP_LW, 1'b1, 1'b0, "lw", st, cb, tmo);
        n3 = 0;
        for (int i = 0; i < 4; i++) begin
            step(OP_LW, (i == 3), 1'b0, "lw_memrd", st, cb, tmo);
            if (st == 4'd3) n3++;
        end
        chk("lw_memrd_cycles", 16'(n3), 16'd4);
        step(OP_LW, 1'b1, 1'b0, "lw_memwb", st, cb, tmo);
        chk("lw_memwb", {st, 10'd0, cb[7], cb[9]}, {4'd4, 10'd0, 2'b11});

        // beq taken then not taken.
        for (int k = 0; k < 2; k++) begin
            p0 = pc_loads;
            step(OP_BEQ, 1'b1, (k == 0), "beq", st, cb, tmo);
            step(OP_BEQ, 1'b1, (k == 0), "beq", st, cb, tmo);
            step(OP_BEQ, 1'b1, (k == 0), "beq_exec", st, cb, tmo);
            chk("beq_ctrl", {st, 9'd0, cb[14], cb[1:0]}, {4'd8, 9'd0, 1'b1, 2'b01});
            chk("beq_pc_loads", 16'(pc_loads - p0), (k == 0) ? 16'd2 : 16'd1);
        end

        // ADDI opcode: enabled build runs AEX/AWB, default build treats it as illegal.
        seq = 16'd0; seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(OP_ADDI, 1'b1, 1'b0, "addi", st, cb, tmo);
            seq = {seq[11:0], st};
            seen = seen | cb[7];
        end
        chk("addi_seq", seq, ADDI_EN ? 16'h01AB : 16'h0101);
        chk("addi_regwrite", 16'(seen), ADDI_EN ? 16'd1 : 16'd0);

        // Reset pulsed while a store waits in MEMWR.
        step(OP_SW, 1'b1, 1'b0, "sw", st, cb, tmo);
        step(OP_SW, 1'b1, 1'b0, "sw", st, cb, tmo);
        step(OP_SW, 1'b1, 1'b0, "sw", st, cb, tmo);
        step(OP_SW, 1'b0, 1'b0, "sw_memwr", st, cb, tmo);
        opcode = OP_SW; mem_ready = 1'b0;
        #1;
        chk("sw_memwrite_before_reset", 16'(MemWrite), 16'd1);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        chk("sw_reset_memwrite", 16'(MemWrite), 16'd0);
        chk("sw_reset_ctrl", ctl_bus, 16'd0);
        chk("sw_reset_state", 16'(state), 16'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(OP_SW, 1'b0, 1'b0, "after_reset", st, cb, tmo);
        chk("after_reset_state", 16'(st), 16'd0);

        // Randomized instruction stream with alternating handshake bias.
        bias = 1; cur_op = OP_RTYP;
        for (int i = 0; i < 400; i++) begin
            if (i % 60 == 0) bias = (bias == 7) ? 1 : 7;
            if (m_state == 0) cur_op = pick_op();
            step(cur_op, ($urandom_range(0, 9) < bias), 1'($urandom_range(0, 1)), "random",
                 st, cb, tmo);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
